// File: rtl/gc_pkg.sv
// Shared constants and types for the GameCube controller input sampler.
package gc_pkg;

  localparam int unsigned BTN_START  = 11;
  localparam int unsigned BTN_Y      = 10;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_B      = 8;
  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_L      = 6;
  localparam int unsigned BTN_R      = 5;
  localparam int unsigned BTN_Z      = 4;
  localparam int unsigned BTN_DUP    = 3;
  localparam int unsigned BTN_DDOWN  = 2;
  localparam int unsigned BTN_DRIGHT = 1;
  localparam int unsigned BTN_DLEFT  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POLL  = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } sampler_state_e;

  localparam logic [7:0] ORIGIN_MIN = 8'd64;
  localparam logic [7:0] ORIGIN_MAX = 8'd192;

  function automatic logic origin_ok(input logic [7:0] v);
    return (v >= ORIGIN_MIN) && (v <= ORIGIN_MAX);
  endfunction

endpackage

// File: rtl/gc_axis_center.sv
// Centres one stick channel against its origin, saturates to +/-127 and applies the dead zone.
module gc_axis_center #(
  parameter int unsigned DEADZONE = 8
) (
  input  logic [7:0] raw_i,
  input  logic [7:0] origin_i,
  output logic [7:0] value_o
);

  localparam logic [8:0] DzLim = 9'(DEADZONE);

  logic signed [8:0] diff;
  logic signed [8:0] sat;
  logic        [8:0] mag;

  always_comb begin
    diff = $signed({1'b0, raw_i}) - $signed({1'b0, origin_i});
    if (diff > 9'sd127) begin
      sat = 9'sd127;
    end else if (diff < -9'sd127) begin
      sat = -9'sd127;
    end else begin
      sat = diff;
    end
    mag     = sat[8] ? 9'(-sat) : 9'(sat);
    value_o = (mag <= DzLim) ? 8'd0 : sat[7:0];
  end

endmodule

// File: rtl/gc_input_sampler.sv
// Poll scheduler and snapshot/calibration stage for a GameCube controller.
// Optional GC_BTN_EDGE_EN adds a btn_pressed output of newly pressed buttons.
module gc_input_sampler
  import gc_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 16666,
  parameter int unsigned RESP_WINDOW = 500,
  parameter int unsigned DEADZONE    = 8
) (
  input  logic        usClock,
  input  logic        Reset,
  input  logic        recal,
  output logic        poll,
  input  logic [11:0] buttons_in,
  input  logic [7:0]  joyX_in,
  input  logic [7:0]  joyY_in,
  input  logic [7:0]  cstickX_in,
  input  logic [7:0]  cstickY_in,
  input  logic [7:0]  lButton_in,
  input  logic [7:0]  rButton_in,
  output logic        sample_valid,
  output logic [11:0] buttons,
  output logic [7:0]  joy_x,
  output logic [7:0]  joy_y,
  output logic [7:0]  cstick_x,
  output logic [7:0]  cstick_y,
  output logic [7:0]  l_analog,
  output logic [7:0]  r_analog,
  output logic        calibrated
`ifdef GC_BTN_EDGE_EN
  ,
  output logic [11:0] btn_pressed
`endif
);

  localparam int unsigned CntW = $clog2(POLL_PERIOD);
  localparam logic [CntW-1:0] CntLast = CntW'(POLL_PERIOD - 1);
  localparam logic [CntW-1:0] CntWin  = CntW'(RESP_WINDOW);

  logic [CntW-1:0] cnt_q, cnt_d;
  sampler_state_e  state_q, state_d;
  logic            poll_q, poll_d;
  logic            sv_q, sv_d;
  logic            cal_q, cal_d;
  logic            pend_q, pend_d;
  logic [11:0]     btn_q, btn_d;
  logic [7:0]      jx_q, jx_d, jy_q, jy_d, cx_q, cx_d, cy_q, cy_d, l_q, l_d, r_q, r_d;
  logic [7:0]      ojx_q, ojx_d, ojy_q, ojy_d, ocx_q, ocx_d, ocy_q, ocy_d;
  logic [7:0]      ol_q, ol_d, or_q, or_d;

  logic       latch, cap_ok;
  logic [7:0] jx_c, jy_c, cx_c, cy_c;
  logic [8:0] l_diff, r_diff;

  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cnt_q == '0) state_d = POLL;
      POLL:    state_d = WAIT;
      WAIT:    if (cnt_q == CntWin) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    poll_d = (state_d == POLL);
  end

  // Origin capture: pending or same-cycle recal, and every stick origin must be plausible.
  always_comb begin
    latch  = (state_q == LATCH);
    cap_ok = latch && (pend_q || recal) &&
             origin_ok(joyX_in) && origin_ok(joyY_in) &&
             origin_ok(cstickX_in) && origin_ok(cstickY_in);

    ojx_d = cap_ok ? joyX_in    : ojx_q;
    ojy_d = cap_ok ? joyY_in    : ojy_q;
    ocx_d = cap_ok ? cstickX_in : ocx_q;
    ocy_d = cap_ok ? cstickY_in : ocy_q;
    ol_d  = cap_ok ? lButton_in : ol_q;
    or_d  = cap_ok ? rButton_in : or_q;

    cal_d = cal_q || cap_ok;
    if (cap_ok) begin
      pend_d = 1'b0;
    end else if (recal) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  gc_axis_center #(.DEADZONE(DEADZONE)) u_center_jx (
    .raw_i(joyX_in), .origin_i(ojx_d), .value_o(jx_c)
  );
  gc_axis_center #(.DEADZONE(DEADZONE)) u_center_jy (
    .raw_i(joyY_in), .origin_i(ojy_d), .value_o(jy_c)
  );
  gc_axis_center #(.DEADZONE(DEADZONE)) u_center_cx (
    .raw_i(cstickX_in), .origin_i(ocx_d), .value_o(cx_c)
  );
  gc_axis_center #(.DEADZONE(DEADZONE)) u_center_cy (
    .raw_i(cstickY_in), .origin_i(ocy_d), .value_o(cy_c)
  );

  always_comb begin
    l_diff = {1'b0, lButton_in} - {1'b0, ol_d};
    r_diff = {1'b0, rButton_in} - {1'b0, or_d};

    sv_d  = latch;
    btn_d = btn_q;
    jx_d  = jx_q;
    jy_d  = jy_q;
    cx_d  = cx_q;
    cy_d  = cy_q;
    l_d   = l_q;
    r_d   = r_q;
    if (latch) begin
      btn_d = buttons_in;
      jx_d  = cal_d ? jx_c : 8'd0;
      jy_d  = cal_d ? jy_c : 8'd0;
      cx_d  = cal_d ? cx_c : 8'd0;
      cy_d  = cal_d ? cy_c : 8'd0;
      l_d   = (cal_d && !l_diff[8]) ? l_diff[7:0] : 8'd0;
      r_d   = (cal_d && !r_diff[8]) ? r_diff[7:0] : 8'd0;
    end
  end

  always_ff @(posedge usClock) begin
    if (Reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      poll_q  <= 1'b0;
      sv_q    <= 1'b0;
      cal_q   <= 1'b0;
      pend_q  <= 1'b1;
      btn_q   <= '0;
      jx_q    <= '0;
      jy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      l_q     <= '0;
      r_q     <= '0;
      ojx_q   <= '0;
      ojy_q   <= '0;
      ocx_q   <= '0;
      ocy_q   <= '0;
      ol_q    <= '0;
      or_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      poll_q  <= poll_d;
      sv_q    <= sv_d;
      cal_q   <= cal_d;
      pend_q  <= pend_d;
      btn_q   <= btn_d;
      jx_q    <= jx_d;
      jy_q    <= jy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      l_q     <= l_d;
      r_q     <= r_d;
      ojx_q   <= ojx_d;
      ojy_q   <= ojy_d;
      ocx_q   <= ocx_d;
      ocy_q   <= ocy_d;
      ol_q    <= ol_d;
      or_q    <= or_d;
    end
  end

  assign poll         = poll_q;
  assign sample_valid = sv_q;
  assign buttons      = btn_q;
  assign joy_x        = jx_q;
  assign joy_y        = jy_q;
  assign cstick_x     = cx_q;
  assign cstick_y     = cy_q;
  assign l_analog     = l_q;
  assign r_analog     = r_q;
  assign calibrated   = cal_q;

`ifdef GC_BTN_EDGE_EN
  // The latched buttons register doubles as the previous-snapshot value.
  logic [11:0] pressed_q, pressed_d;

  always_comb begin
    pressed_d = latch ? (buttons_in & ~btn_q) : 12'd0;
  end

  always_ff @(posedge usClock) begin
    if (Reset) begin
      pressed_q <= '0;
    end else begin
      pressed_q <= pressed_d;
    end
  end

  assign btn_pressed = pressed_q;
`endif

endmodule

// File: tb/tb_gc_input_sampler.sv
// Scoreboard bench for gc_input_sampler: random stimulus against an integer reference model.
module tb_gc_input_sampler;
  import gc_pkg::*;

  localparam int PERIOD    = 100;
  localparam int RW        = 40;
  localparam int DZ        = 8;
  localparam int LATCH_PH  = RW + 1;
  localparam int STROBE_PH = RW + 2;

  logic        usClock = 1'b0;
  logic        Reset, recal, poll, sample_valid, calibrated;
  logic [11:0] buttons_in, buttons;
  logic [7:0]  joyX_in, joyY_in, cstickX_in, cstickY_in, lButton_in, rButton_in;
  logic [7:0]  joy_x, joy_y, cstick_x, cstick_y, l_analog, r_analog;
`ifdef GC_BTN_EDGE_EN
  logic [11:0] btn_pressed;
`endif

  always #5 usClock = ~usClock;

  gc_input_sampler #(.POLL_PERIOD(PERIOD), .RESP_WINDOW(RW), .DEADZONE(DZ)) dut (
    .usClock(usClock), .Reset(Reset), .recal(recal), .poll(poll),
    .buttons_in(buttons_in), .joyX_in(joyX_in), .joyY_in(joyY_in),
    .cstickX_in(cstickX_in), .cstickY_in(cstickY_in),
    .lButton_in(lButton_in), .rButton_in(rButton_in),
    .sample_valid(sample_valid), .buttons(buttons), .joy_x(joy_x), .joy_y(joy_y),
    .cstick_x(cstick_x), .cstick_y(cstick_y), .l_analog(l_analog), .r_analog(r_analog),
    .calibrated(calibrated)
`ifdef GC_BTN_EDGE_EN
    , .btn_pressed(btn_pressed)
`endif
  );

  typedef struct packed {
    logic [11:0] b;
    logic [7:0]  jx, jy, cx, cy, l, r;
    logic        cal;
    logic [11:0] pr;
  } snap_t;

  snap_t       exp_q[$];
  snap_t       hold = '0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          epoch = 0;
  bit          mon_en = 0;

  int          org[6];
  bit          m_cal, m_pend;
  logic [11:0] m_prev;

  function automatic int center(input int raw, input int o);
    int d = raw - o;
    if (d > 127) d = 127;
    if (d < -127) d = -127;
    if (d >= -DZ && d <= DZ) d = 0;
    return d;
  endfunction

  function automatic int trig(input int raw, input int o);
    return (raw > o) ? raw - o : 0;
  endfunction

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) org[i] = 0;
    m_cal  = 0;
    m_pend = 1;
    m_prev = '0;
  endtask

  task automatic model_latch(input logic [11:0] b, input int v[6], input bit rc);
    snap_t s;
    bit    ok = 1;
    for (int i = 0; i < 4; i++) if (v[i] < 64 || v[i] > 192) ok = 0;
    if (m_pend || rc) begin
      if (ok) begin
        for (int i = 0; i < 6; i++) org[i] = v[i];
        m_cal  = 1;
        m_pend = 0;
      end else begin
        m_pend = 1;
      end
    end
    s     = '0;
    s.b   = b;
    s.cal = m_cal;
    if (m_cal) begin
      s.jx = 8'(center(v[0], org[0]));
      s.jy = 8'(center(v[1], org[1]));
      s.cx = 8'(center(v[2], org[2]));
      s.cy = 8'(center(v[3], org[3]));
      s.l  = 8'(trig(v[4], org[4]));
      s.r  = 8'(trig(v[5], org[5]));
    end
    s.pr   = b & ~m_prev;
    m_prev = b;
    exp_q.push_back(s);
  endtask

  task automatic set_inputs(input logic [11:0] b, input int v[6]);
    buttons_in = b;
    joyX_in    = 8'(v[0]);
    joyY_in    = 8'(v[1]);
    cstickX_in = 8'(v[2]);
    cstickY_in = 8'(v[3]);
    lButton_in = 8'(v[4]);
    rButton_in = 8'(v[5]);
  endtask

  task automatic advance();
    @(posedge usClock);
    cyc++;
    #1;
  endtask

  // Inputs carry noise except in the LATCH cycle, where the stimulus values are applied.
  task automatic run_period(input logic [11:0] b, input int v[6], input int recal_ph,
                            input int rst_ph);
    int g[6];
    for (int p = 0; p < PERIOD; p++) begin
      recal = (p == recal_ph);
      if (p == LATCH_PH) begin
        set_inputs(b, v);
        model_latch(b, v, recal);
      end else begin
        for (int i = 0; i < 6; i++) g[i] = int'($urandom_range(0, 255));
        set_inputs(12'($urandom), g);
        if (recal) m_pend = 1;
      end
      if (p == rst_ph) begin
        Reset = 1'b1;
        advance();
        Reset = 1'b0;
        recal = 1'b0;
        epoch = cyc;
        model_reset();
        return;
      end
      advance();
    end
    recal = 1'b0;
  endtask

  always @(negedge usClock) begin
    int    ph;
    snap_t cur, want;
    if (mon_en) begin
      ph = (cyc - epoch) % PERIOD;
      check("poll", int'(poll), int'(ph == 1));
      check("sample_valid", int'(sample_valid), int'(ph == STROBE_PH));
      cur = '{b: buttons, jx: joy_x, jy: joy_y, cx: cstick_x, cy: cstick_y,
              l: l_analog, r: r_analog, cal: calibrated, pr: 12'd0};
`ifdef GC_BTN_EDGE_EN
      cur.pr = btn_pressed;
`endif
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe cyc=%0d got=strobe want=none", cyc);
        end else begin
          want = exp_q.pop_front();
`ifndef GC_BTN_EDGE_EN
          want.pr = 12'd0;
`endif
          check("buttons", int'(cur.b), int'(want.b));
          check("joy_x", int'(cur.jx), int'(want.jx));
          check("joy_y", int'(cur.jy), int'(want.jy));
          check("cstick_x", int'(cur.cx), int'(want.cx));
          check("cstick_y", int'(cur.cy), int'(want.cy));
          check("l_analog", int'(cur.l), int'(want.l));
          check("r_analog", int'(cur.r), int'(want.r));
          check("calibrated", int'(cur.cal), int'(want.cal));
          check("btn_pressed", int'(cur.pr), int'(want.pr));
          hold    = want;
          hold.pr = 12'd0;
        end
      end else begin
        checks++;
        if (cur !== hold) begin
          failures++;
          $display("FAIL hold cyc=%0d got=%h want=%h", cyc, cur, hold);
        end
      end
      if (Reset) begin
        hold = '0;
        exp_q.delete();
      end
    end
  end

  initial begin
    int       v[6];
    logic [11:0] b;
    int       rc, rp;
    Reset = 1'b1;
    recal = 1'b0;
    v     = '{0, 0, 0, 0, 0, 0};
    set_inputs(12'd0, v);
    model_reset();
    repeat (3) @(posedge usClock);
    #1;
    Reset  = 1'b0;
    cyc    = 0;
    epoch  = 0;
    mon_en = 1;

    b = 12'd0;
    b[BTN_A] = 1'b1;
    run_period(b, '{128, 128, 128, 128, 20, 30}, -1, -1);
    run_period(b, '{200, 20, 135, 255, 10, 200}, 60, -1);
    run_period(b, '{140, 140, 140, 140, 20, 30}, -1, -1);
    run_period(12'h0f0, '{128, 128, 128, 128, 0, 0}, -1, 20);
    run_period(12'h801, '{250, 128, 128, 128, 0, 0}, -1, -1);
    run_period(12'h801, '{128, 128, 128, 128, 20, 30}, -1, -1);
    run_period(12'h002, '{135, 121, 128, 128, 10, 200}, -1, -1);
    run_period(12'h002, '{255, 0, 64, 192, 255, 0}, -1, -1);

    for (int n = 0; n < 24; n++) begin
      rc = int'($urandom_range(0, 5));
      rp = (rc == 0) ? LATCH_PH : (rc == 1) ? 70 : -1;
      for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(70, 190));
      b = 12'($urandom);
      run_period(b, v, rp, -1);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
